// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the pipeline sequencing controller.
//   state_e    : controller FSM states
//   OP_*       : opcode prefix constants matched against op = Instruction[IW-1 -: 8]
//   ISEL_*     : InputSelector encodings
//   strobes_t  : bundle of the decode strobes registered by pipe_ctrl
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_REPEAT = 3'd2,
      ST_FLUSH  = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   localparam logic [3:0] OP_MEMWR   = 4'b0101;
   localparam logic [5:0] OP_INCLFSR = 6'b011000;
   localparam logic [5:0] OP_LFSRWR  = 6'b011010;
   localparam logic [5:0] OP_TAPS    = 6'b011011;
   localparam logic [3:0] OP_BR      = 4'b0001;
   localparam logic [3:0] OP_BRNP    = 4'b0010;
   localparam logic [3:0] OP_BRNEG   = 4'b0011;
   localparam logic [3:0] OP_BRNZ    = 4'b0100;
   localparam logic [7:0] OP_ACK     = 8'h00;
   localparam logic [3:0] OP_NOREG   = 4'b1101;
   localparam logic [4:0] OP_REG5    = 5'b01100;
   localparam logic [3:0] OP_REG4    = 4'b0111;

   localparam logic [1:0] ISEL_ALU = 2'b00;
   localparam logic [1:0] ISEL_MEM = 2'b01;
   localparam logic [1:0] ISEL_IMM = 2'b10;
   localparam logic [1:0] ISEL_REG = 2'b11;

   typedef struct packed {
      logic mem_wr;
      logic reg_wr;
      logic lfsr_wr;
      logic taps;
      logic inc_lfsr;
      logic branch;
      logic ack;
   } strobes_t;

endpackage

// File: rtl/pipe_ctrl_dec.sv
// pipe_ctrl_dec -- combinational decode of one 8-bit opcode.
//   op_i                      : opcode byte
//   non_zero_i/parity_i/
//   negative_i                : ALU flags used by conditional branches
//   strb_o                    : decoded strobes (before registering)
//   in_sel_o                  : decoded datapath input select
module pipe_ctrl_dec
   import pipe_ctrl_pkg::*;
(
   input  logic [7:0] op_i,
   input  logic       non_zero_i,
   input  logic       parity_i,
   input  logic       negative_i,
   output strobes_t   strb_o,
   output logic [1:0] in_sel_o
);

   always_comb begin
      strb_o          = '0;
      strb_o.mem_wr   = (op_i[7:4] == OP_MEMWR);
      strb_o.reg_wr   = (op_i[7] && (op_i[7:4] != OP_NOREG))
                        || (op_i[7:3] == OP_REG5)
                        || (op_i[7:4] == OP_REG4);
      strb_o.lfsr_wr  = (op_i[7:2] == OP_LFSRWR);
      strb_o.taps     = (op_i[7:2] == OP_TAPS);
      strb_o.inc_lfsr = (op_i[7:2] == OP_INCLFSR);
      strb_o.ack      = (op_i == OP_ACK);
      case (op_i[7:4])
         OP_BR:    strb_o.branch = 1'b1;
         OP_BRNP:  strb_o.branch = ~parity_i;
         OP_BRNEG: strb_o.branch = negative_i;
         OP_BRNZ:  strb_o.branch = non_zero_i;
         default:  strb_o.branch = 1'b0;
      endcase
   end

   always_comb begin
      if (op_i[7])
         in_sel_o = ISEL_ALU;
      else if (!op_i[4] && op_i[2])
         in_sel_o = ISEL_IMM;
      else if (!op_i[4] && !op_i[2])
         in_sel_o = ISEL_REG;
      else
         in_sel_o = ISEL_MEM;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- instruction-issue sequencer with registered decode strobes.
// Optional feature macro: PIPE_CTRL_FLUSH_EN (one FLUSH bubble after a taken branch).
//   Clk, Reset (sync, active-high), Start
//   InstrValid/InstrReady handshake, Instruction[IW-1:0] (opcode in top 8 bits)
//   NonZero, Parity, Negative  : ALU flags
//   MemWrEn, RegWrEn, LFSRWrEn, TapsEn, IncLFSR, BranchEn, Ack : registered strobes
//   InputSelector[1:0]         : registered datapath select, held between accepts
//   Busy                       : high in RUN, REPEAT and FLUSH
//
// state  | meaning
// IDLE   | after reset, waits for Start
// RUN    | accepts instructions (InstrReady=1)
// REPEAT | replays IncLFSR for the remaining steps of a multi-step increment
// FLUSH  | one-cycle bubble after a taken branch (PIPE_CTRL_FLUSH_EN only)
// HALT   | after op 8'h00, Ack held until Start
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int IW    = 8,
   parameter int REP_W = 2
)(
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          InstrValid,
   input  logic [IW-1:0] Instruction,
   input  logic          NonZero,
   input  logic          Parity,
   input  logic          Negative,
   output logic          InstrReady,
   output logic          MemWrEn,
   output logic          RegWrEn,
   output logic          LFSRWrEn,
   output logic          TapsEn,
   output logic          IncLFSR,
   output logic          BranchEn,
   output logic          Ack,
   output logic [1:0]    InputSelector,
   output logic          Busy
);

   logic [7:0]       op;
   logic [REP_W-1:0] rep;
   strobes_t         dec_strb;
   logic [1:0]       dec_sel;

   state_e           state_q, state_d;
   strobes_t         strb_q, strb_d;
   logic [1:0]       sel_q, sel_d;
   logic [REP_W-1:0] rem_q, rem_d;

   assign op  = Instruction[IW-1 -: 8];
   assign rep = op[REP_W-1:0];

   generate
      if (IW > 8) begin : g_low_bits
         logic unused_low;
         assign unused_low = ^Instruction[IW-9:0];
      end
   endgenerate

   pipe_ctrl_dec u_dec (
      .op_i       (op),
      .non_zero_i (NonZero),
      .parity_i   (Parity),
      .negative_i (Negative),
      .strb_o     (dec_strb),
      .in_sel_o   (dec_sel)
   );

   // rem_q counts IncLFSR steps still to issue after the first one.
   always_comb begin
      state_d = state_q;
      strb_d  = '0;
      sel_d   = sel_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (Start) state_d = ST_RUN;
         end
         ST_HALT: begin
            strb_d.ack = 1'b1;
            if (Start) begin
               state_d    = ST_RUN;
               strb_d.ack = 1'b0;
            end
         end
         ST_RUN: begin
            if (InstrValid) begin
               strb_d = dec_strb;
               sel_d  = dec_sel;
               if (dec_strb.ack) begin
                  state_d = ST_HALT;
               end else if (dec_strb.inc_lfsr && (rep != '0)) begin
                  state_d = ST_REPEAT;
                  rem_d   = rep;
               end
`ifdef PIPE_CTRL_FLUSH_EN
               else if (dec_strb.branch) begin
                  state_d = ST_FLUSH;
               end
`endif
            end
         end
         ST_REPEAT: begin
            strb_d.inc_lfsr = 1'b1;
            rem_d           = rem_q - REP_W'(1);
            if (rem_q == REP_W'(1)) state_d = ST_RUN;
         end
`ifdef PIPE_CTRL_FLUSH_EN
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         strb_q  <= '0;
         sel_q   <= ISEL_ALU;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         strb_q  <= strb_d;
         sel_q   <= sel_d;
         rem_q   <= rem_d;
      end
   end

   assign InstrReady    = (state_q == ST_RUN);
   assign Busy          = (state_q == ST_RUN) || (state_q == ST_REPEAT) || (state_q == ST_FLUSH);
   assign MemWrEn       = strb_q.mem_wr;
   assign RegWrEn       = strb_q.reg_wr;
   assign LFSRWrEn      = strb_q.lfsr_wr;
   assign TapsEn        = strb_q.taps;
   assign IncLFSR       = strb_q.inc_lfsr;
   assign BranchEn      = strb_q.branch;
   assign Ack           = strb_q.ack;
   assign InputSelector = sel_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter IW, default 8, instruction width in bits (legal range IW >= 8).
REQ-002 SHALL have parameter REP_W, default 2, width of the IncLFSR repeat field.
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  leaves IDLE or HALT and enters RUN.
REQ-006 SHALL have port InstrValid  input  1  Instruction is valid this cycle.
REQ-007 SHALL have port Instruction  input  IW  instruction word; opcode op = Instruction[IW-1 -: 8].
REQ-008 SHALL have ports NonZero, Parity, Negative  input  1 each  ALU flags.
REQ-009 SHALL have port InstrReady  output  1  instruction accepted when InstrValid and InstrReady are both high.
REQ-010 SHALL have ports MemWrEn, RegWrEn, LFSRWrEn, TapsEn, IncLFSR, BranchEn, Ack  output  1 each  registered decode strobes.
REQ-011 SHALL have port InputSelector  output  2  registered datapath input select.
REQ-012 SHALL have port Busy  output  1  high in RUN, REPEAT and FLUSH.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, REPEAT, FLUSH and HALT.
REQ-014 SHALL drive InstrReady=1 only in RUN.
REQ-015 SHALL go IDLE->RUN and HALT->RUN on Start; otherwise it SHALL hold the current state.
REQ-016 SHALL register decode outputs with 1-cycle latency: an instruction accepted in cycle N drives its outputs in cycle N+1.
REQ-017 SHALL set MemWrEn = (op[7:4]==0101).
REQ-018 SHALL set RegWrEn = (op[7] && op[7:4]!=1101) || op[7:3]==01100 || op[7:4]==0111.
REQ-019 SHALL set LFSRWrEn = (op[7:2]==011010), TapsEn = (op[7:2]==011011) and IncLFSR = (op[7:2]==011000).
REQ-020 SHALL set BranchEn as: op[7:4]==0001 -> 1; 0010 -> ~Parity; 0011 -> Negative; 0100 -> NonZero; otherwise 0, using flags sampled in the accept cycle.
REQ-021 SHALL decode InputSelector as: op[7] -> 00; else !op[4]&&op[2] -> 10; else !op[4]&&!op[2] -> 11; else 01.
REQ-022 SHALL hold InputSelector at its last value when no instruction is accepted.
REQ-023 SHALL drive all strobes to 0 in any cycle that follows no accept and no repeat.
REQ-024 SHALL treat an IncLFSR opcode as a repeat count of op[REP_W-1:0]+1 steps (1..4 at default).
REQ-025 SHALL, for a repeat count greater than 1, move RUN->REPEAT and hold IncLFSR high for exactly that many consecutive cycles.
REQ-026 SHALL assert RegWrEn only in the first cycle of a repeat sequence.
REQ-027 SHALL drive InstrReady=0 while in REPEAT and return to RUN after the final step.
REQ-028 SHALL, on accepting op==8'h00, raise Ack for the cycle after the accept and enter HALT.
REQ-029 SHALL hold Ack high and Busy and InstrReady low throughout HALT, and clear Ack on the cycle after Start.
REQ-030 SHALL give Reset priority over Start, and Start priority over InstrValid.
REQ-031 SHALL ignore Start while in RUN, REPEAT or FLUSH.
REQ-032 SHALL ignore Instruction bits below IW-8 except the repeat field.

Reset
REQ-033 SHALL, on Reset, enter IDLE and drive every strobe, InstrReady, Busy and InputSelector to 0 on the next cycle.
REQ-034 SHALL abort any REPEAT or FLUSH in progress when Reset is asserted, with no residual IncLFSR pulse.

Configuration
REQ-035 SHALL, with macro PIPE_CTRL_FLUSH_EN defined, follow each taken branch (BranchEn=1) with one FLUSH cycle: InstrReady=0, strobes 0, then RUN.
REQ-036 SHALL, without PIPE_CTRL_FLUSH_EN, omit the FLUSH state and keep InstrReady=1 after a taken branch.

Structure
REQ-037 SHALL place in shared package pipe_ctrl_pkg: the FSM state enum, opcode prefix constants (OP_MEMWR, OP_INCLFSR, OP_LFSRWR, OP_TAPS, OP_BR*, OP_ACK) and the InputSelector encodings.
REQ-038 SHALL implement the combinational 8-bit opcode decode in one sub-module, pipe_ctrl_dec, which pipe_ctrl registers.

Verification
REQ-039 SHALL cover: Reset, Start, then accept 8'h50 -> next cycle MemWrEn=1, InputSelector=01, all other strobes 0.
REQ-040 SHALL cover: accept 8'h62 -> IncLFSR=1 for 3 cycles, RegWrEn=1 only in the first, InstrReady=0 for 2 cycles.
REQ-041 SHALL cover: accept 8'h40 with NonZero=1 -> BranchEn=1; with PIPE_CTRL_FLUSH_EN, InstrReady=0 for 1 cycle; without it, InstrReady stays 1.
REQ-042 SHALL cover: accept 8'h00 -> Ack=1 held for 5 idle cycles with InstrReady=0; then Start -> Ack=0 and Busy=1.
REQ-043 SHALL cover: Reset asserted during the second step of 8'h63 -> next cycle all outputs 0 and state IDLE.
REQ-044 SHALL cover: IW=12 with Instruction=12'h8A5 -> RegWrEn=1 and InputSelector=00, low nibble ignored.
